desplazador_secuencial: RTL and testbench

- Multi-cycle shift/rotate unit for the datapath's shift instructions: one bit position per clock, start/done handshake to the control unit.
- Complements the single-cycle combinational logical left/right shifter: adds arithmetic right shift and rotate-right.
- Sits beside the ALU; control stalls the pipeline while busy is high.

---
 rtl/desplazador_secuencial.sv | 94 +++++++++
 tb/tb_desplazador_secuencial.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/desplazador_secuencial.sv
// rtl/desplazador_secuencial.sv - multi-cycle shift/rotate unit, one bit position per clock
// Handles SLL/SRL/SRA/ROR with a start/done handshake; busy tells control to stall.
module desplazador_secuencial #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [SHW-1:0]   cnt;
  logic [1:0]       op_q;

  assign busy = (state != IDLE);

  // Single-position step of the captured operation
  always_comb begin
    shreg_next = shreg;
    case (op_q)
      OP_SLL:  shreg_next = {shreg[WIDTH-2:0], 1'b0};
      OP_SRL:  shreg_next = {1'b0, shreg[WIDTH-1:1]};
      OP_SRA:  shreg_next = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      OP_ROR:  shreg_next = {shreg[0], shreg[WIDTH-1:1]};
      default: shreg_next = shreg;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      op_q   <= OP_SLL;
      done   <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg <= data_in;
            cnt   <= shamt;
            op_q  <= op;
            if (shamt != '0) begin
              state <= SHIFT;
            end else begin
              // Zero shift goes straight to DONE with the operand as result
              state  <= DONE;
              done   <= 1'b1;
              result <= data_in;
            end
          end
        end
        SHIFT: begin
          shreg <= shreg_next;
          cnt   <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            state  <= DONE;
            done   <= 1'b1;
            result <= shreg_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_desplazador_secuencial.sv
// tb/tb_desplazador_secuencial.sv - directed self-checking bench for desplazador_secuencial
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_desplazador_secuencial;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [1:0]  op;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int passed;
  int total;

  desplazador_secuencial #(.WIDTH(32), .SHW(5)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .data_in (data_in),
    .shamt   (shamt),
    .op      (op),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts falling-edge samples until done; cycles = -1 on timeout
  task automatic wait_done(output int cycles, output int busy_cycles);
    cycles = -1;
    busy_cycles = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (done) begin
        cycles = i;
        return;
      end
    end
  endtask

  // Presents one request, lets edge E0 accept it, then drops start
  task automatic issue(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
    @(posedge clk);
    #1;
    data_in = d;
    shamt   = s;
    op      = o;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, result} !== 34'd0) $display("FAIL reset_async: busy=%0b done=%0b result=%h, want 0 0 00000000", busy, done, result);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({busy, done, result} !== 34'd0) $display("FAIL reset_idle_%0d: busy=%0b done=%0b result=%h, want 0 0 00000000", i, busy, done, result);
      else passed++;
    end
  endtask

  task automatic test_sll();
    int cyc, bcyc;
    issue(32'h0000_00F1, 5'd4, 2'b00);
    wait_done(cyc, bcyc);
    total++;
    if (cyc !== 4) $display("FAIL sll_latency: done after %0d cycles, want 4", cyc);
    else passed++;
    total++;
    if (bcyc !== 5) $display("FAIL sll_busy: busy for %0d cycles, want 5", bcyc);
    else passed++;
    total++;
    if (result !== 32'h0000_0F10) $display("FAIL sll_result: got %h want 00000f10", result);
    else passed++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL sll_done_pulse: done=%0b busy=%0b, want 0 0", done, busy);
    else passed++;
    @(negedge clk);
    total++;
    if (result !== 32'h0000_0F10) $display("FAIL sll_hold: got %h want 00000f10", result);
    else passed++;
  endtask

  task automatic test_sra_srl();
    int cyc, bcyc;
    issue(32'h8000_0010, 5'd4, 2'b10);
    wait_done(cyc, bcyc);
    total++;
    if (result !== 32'hF800_0001) $display("FAIL sra_result: got %h want f8000001", result);
    else passed++;
    issue(32'h8000_0010, 5'd4, 2'b01);
    wait_done(cyc, bcyc);
    total++;
    if (result !== 32'h0800_0001) $display("FAIL srl_result: got %h want 08000001", result);
    else passed++;
    issue(32'h8000_0000, 5'd31, 2'b10);
    wait_done(cyc, bcyc);
    total++;
    if (cyc !== 31) $display("FAIL sra31_latency: done after %0d cycles, want 31", cyc);
    else passed++;
    total++;
    if (result !== 32'hFFFF_FFFF) $display("FAIL sra31_result: got %h want ffffffff", result);
    else passed++;
  endtask

  task automatic test_ror_zero();
    int cyc, bcyc;
    issue(32'h1234_5678, 5'd8, 2'b11);
    wait_done(cyc, bcyc);
    total++;
    if (result !== 32'h7812_3456) $display("FAIL ror_result: got %h want 78123456", result);
    else passed++;
    issue(32'h1234_5678, 5'd0, 2'b00);
    wait_done(cyc, bcyc);
    total++;
    if (cyc !== 0) $display("FAIL zero_latency: done after %0d cycles, want 0", cyc);
    else passed++;
    total++;
    if (result !== 32'h1234_5678) $display("FAIL zero_result: got %h want 12345678", result);
    else passed++;
  endtask

  task automatic test_handshake();
    int cyc, bcyc;
    issue(32'h8000_0010, 5'd4, 2'b01);
    @(posedge clk);
    #1;
    data_in = 32'hFFFF_FFFF;
    shamt   = 5'd1;
    op      = 2'b00;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcyc);
    total++;
    if (cyc !== 2) $display("FAIL ignore_latency: done after %0d more cycles, want 2", cyc);
    else passed++;
    total++;
    if (result !== 32'h0800_0001) $display("FAIL ignore_result: got %h want 08000001", result);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    @(posedge clk);
    #1;
    data_in = 32'h0000_00F1;
    shamt   = 5'd2;
    op      = 2'b00;
    start   = 1'b1;
    @(posedge clk);
    #1;
    data_in = 32'h8000_0000;
    shamt   = 5'd3;
    op      = 2'b10;
    wait_done(cyc, bcyc);
    total++;
    if (cyc !== 2 || result !== 32'h0000_03C4) $display("FAIL b2b_first: cycles=%0d result=%h, want 2 000003c4", cyc, result);
    else passed++;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0000_03C4) $display("FAIL b2b_gap: busy=%0b done=%0b result=%h, want 0 0 000003c4", busy, done, result);
    else passed++;
    @(posedge clk);
    #1;
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || result !== 32'h0000_03C4) $display("FAIL b2b_accept: busy=%0b result=%h, want 1 000003c4", busy, result);
    else passed++;
    wait_done(cyc, bcyc);
    total++;
    if (cyc !== 3 || result !== 32'hF000_0000) $display("FAIL b2b_second: cycles=%0d result=%h, want 3 f0000000", cyc, result);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int cyc, bcyc;
    issue(32'hFFFF_FFFF, 5'd20, 2'b01);
    repeat (7) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    total++;
    if ({busy, done, result} !== 34'd0) $display("FAIL reset_mid: busy=%0b done=%0b result=%h, want 0 0 00000000", busy, done, result);
    else passed++;
    @(negedge clk);
    reset = 1'b0;
    issue(32'hFFFF_FFFF, 5'd20, 2'b01);
    wait_done(cyc, bcyc);
    total++;
    if (cyc !== 20 || result !== 32'h0000_0FFF) $display("FAIL reset_resume: cycles=%0d result=%h, want 20 00000fff", cyc, result);
    else passed++;
  endtask

  initial begin
    passed  = 0;
    total   = 0;
    reset   = 1'b1;
    start   = 1'b0;
    data_in = '0;
    shamt   = '0;
    op      = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_sll();
    test_sra_srl();
    test_ror_zero();
    test_handshake();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
